ksa: RTL and testbench
======================

KSA -- requirements
Module: ksa

Interface
REQ-001 Parameter: none; widths fixed (8-bit S-memory data/address, 24-bit key).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  start request; sampled only while rdy=1.
REQ-005 rdy  output  1  1 = idle, may accept en; 0 = busy.
REQ-006 key  input  24  cipher key; byte order key[23:16], key[15:8], key[7:0].
REQ-007 addr  output  8  S-memory address (read and write).
REQ-008 rddata  input  8  S-memory read data, valid one cycle after addr presented.
REQ-009 wrdata  output  8  S-memory write data.
REQ-010 wren  output  1  S-memory write enable, one write per cycle.

Function
REQ-011 SHALL execute the ARC4 key schedule on an S-memory pre-filled with S[i]=i by the init stage.
- j=0; for i=0..255: j=(j+S[i]+key byte [i mod 3]) mod 256; swap S[i],S[j].
REQ-012 Key byte selection: i mod 3 = 0 -> key[23:16]; 1 -> key[15:8]; 2 -> key[7:0].
REQ-013 SHALL latch key on the start cycle; key changes while busy have no effect.
REQ-014 Start: rising edge with rdy=1 and en=1 -> rdy=0 from the next cycle; en while rdy=0 is ignored.
REQ-015 FSM states: IDLE, RD_I, LAT_SI, RD_J, WR_I, WR_J; one cycle each except IDLE.
REQ-016 RD_I: addr=i, wren=0.
REQ-017 LAT_SI: capture si=rddata; register j=(j+si+keybyte) mod 256 (8-bit wrap); wren=0.
REQ-018 RD_J: addr=j (new value), wren=0.
REQ-019 WR_I: addr=i, wrdata=rddata (=S[j]), wren=1.
REQ-020 WR_J: addr=j, wrdata=si, wren=1; then i=i+1, next RD_I; if i was 255, next IDLE.
REQ-021 Each iteration takes exactly 5 cycles; rdy stays 0 for exactly 1280 cycles per run.
REQ-022 i==j: both writes target the same address with the same value; no special-casing.
REQ-023 IDLE: wren=0; addr, wrdata hold their last values.
REQ-024 Arithmetic: i and j are 8-bit and wrap mod 256; the i increment after 255 is never used.
REQ-025 Returning to IDLE sets rdy=1 and clears i and j to 0; immediate back-to-back restart is allowed.

Reset
REQ-026 rst=1 asynchronously forces IDLE; rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0, si=0, latched key=0.
REQ-027 Reset mid-run aborts the schedule; no further writes. S-memory contents are undefined; a re-init is required.
REQ-028 The first start is accepted on the first rising edge after rst deasserts.

Structure
REQ-029 Shared package arc4_pkg holds the FSM state enum, KEY_BYTES=3 and MEM_DEPTH=256.
- This package is shared with the init and PRGA stages.
REQ-030 Single module; no sub-module. The key-byte selector is an inline mod-3 counter advanced with i.

Verification
REQ-031 Reset then idle: rdy=1, wren=0, addr=0 immediately after rst, without a clock edge.
REQ-032 Identity S, key=24'h1E4600: first writes are (addr 00, data 1E), (addr 1E, data 00), (addr 01, data 65), (addr 65, data 01).
REQ-033 Identity S, key=24'h000000: i=0 gives j=0; writes are (00, 00) twice (i==j path).
REQ-034 Latency: en pulse at edge k -> rdy=0 at edges k+1..k+1280, rdy=1 at k+1281; en pulses while busy cause no restart.
REQ-035 rst pulse at mid-run (i=0x80) -> wren=0 and rdy=1 at once; a new en runs a full 1280 cycles.
REQ-036 Full run, key=24'h00033C: final S-memory matches a golden ARC4 KSA model byte-for-byte.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions used by the init, key-schedule and PRGA stages.
package arc4_pkg;

   // Number of key bytes cycled through by the key schedule
   localparam int KEY_BYTES = 3;

   // Number of entries in the S permutation memory
   localparam int MEM_DEPTH = 256;

   // Index of the last S entry, used to detect the final iteration
   localparam logic [7:0] LAST_IDX = 8'(MEM_DEPTH - 1);

   // Key-schedule controller states; every state except IDLE lasts one cycle
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_I   = 3'd1,
      ST_LAT_SI = 3'd2,
      ST_RD_J   = 3'd3,
      ST_WR_I   = 3'd4,
      ST_WR_J   = 3'd5
   } ksa_state_t;

   // Select key byte by position: 0 -> key[23:16], 1 -> key[15:8], 2 -> key[7:0]
   function automatic logic [7:0] key_byte(input logic [23:0] k, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = k[23:16];
         2'd1:    b = k[15:8];
         2'd2:    b = k[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ksa.sv
// ARC4 key-schedule stage: permutes an identity-initialised S memory with a
// 24-bit key. Five cycles per index i, 256 indices per run.
module ksa
   import arc4_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic [7:0]  addr,
   input  logic [7:0]  rddata,
   output logic [7:0]  wrdata,
   output logic        wren
);

   ksa_state_t  r_state;
   logic        r_rdy;
   logic        r_wren;
   logic [7:0]  r_addr;
   logic [7:0]  r_wrdata;
   logic        r_pass;     // high in WR_I: write data comes straight from memory (S[j])
   logic [7:0]  r_i;
   logic [7:0]  r_j;
   logic [7:0]  r_si;
   logic [1:0]  r_kidx;     // i mod 3, advanced together with i
   logic [23:0] r_key;

   logic [7:0]  w_kbyte;
   logic [7:0]  w_jnext;

   // Key byte for the current i and the updated j (8-bit arithmetic wraps mod 256)
   always_comb begin
      w_kbyte = key_byte(r_key, r_kidx);
      w_jnext = r_j + rddata + w_kbyte;
   end

   // Controller: state sequencing, index bookkeeping and registered memory interface
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_rdy    <= 1'b1;
         r_wren   <= 1'b0;
         r_addr   <= 8'h00;
         r_wrdata <= 8'h00;
         r_pass   <= 1'b0;
         r_i      <= 8'h00;
         r_j      <= 8'h00;
         r_si     <= 8'h00;
         r_kidx   <= 2'd0;
         r_key    <= 24'h000000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_wren <= 1'b0;
               r_pass <= 1'b0;
               if (en) begin
                  r_key   <= key;
                  r_i     <= 8'h00;
                  r_j     <= 8'h00;
                  r_kidx  <= 2'd0;
                  r_addr  <= 8'h00;
                  r_rdy   <= 1'b0;
                  r_state <= ST_RD_I;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RD_I: begin
               // addr already holds i; the read data arrives next cycle
               r_wren  <= 1'b0;
               r_state <= ST_LAT_SI;
            end
            ST_LAT_SI: begin
               r_si    <= rddata;
               r_j     <= w_jnext;
               r_addr  <= w_jnext;
               r_state <= ST_RD_J;
            end
            ST_RD_J: begin
               // S[j] returns during WR_I and is forwarded to wrdata directly
               r_addr  <= r_i;
               r_wren  <= 1'b1;
               r_pass  <= 1'b1;
               r_state <= ST_WR_I;
            end
            ST_WR_I: begin
               r_addr   <= r_j;
               r_wrdata <= r_si;
               r_pass   <= 1'b0;
               r_wren   <= 1'b1;
               r_state  <= ST_WR_J;
            end
            ST_WR_J: begin
               r_wren <= 1'b0;
               if (r_i == LAST_IDX) begin
                  r_i     <= 8'h00;
                  r_j     <= 8'h00;
                  r_kidx  <= 2'd0;
                  r_rdy   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_i     <= r_i + 8'd1;
                  r_addr  <= r_i + 8'd1;
                  r_kidx  <= (r_kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : r_kidx + 2'd1;
                  r_state <= ST_RD_I;
               end
            end
            default: begin
               r_wren  <= 1'b0;
               r_pass  <= 1'b0;
               r_rdy   <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rdy    = r_rdy;
   assign wren   = r_wren;
   assign addr   = r_addr;
   assign wrdata = r_pass ? rddata : r_wrdata;

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: synchronous-read S memory model plus a
// behavioural ARC4 key-schedule reference computed with plain arithmetic.
module tb_ksa;

   logic        clk;
   logic        rst;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  addr;
   logic [7:0]  rddata;
   logic [7:0]  wrdata;
   logic        wren;

   logic [7:0]  mem [0:255];
   logic        fill_req;
   logic [15:0] wq [$];
   int          gold [0:255];

   int n_total;
   int n_pass;

   ksa dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .rdy    (rdy),
      .key    (key),
      .addr   (addr),
      .rddata (rddata),
      .wrdata (wrdata),
      .wren   (wren)
   );

   // 100 MHz-style free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // S memory: identity fill on request, otherwise one write per cycle, registered read
   always @(posedge clk) begin
      if (fill_req) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      end else if (wren === 1'b1) begin
         mem[addr] <= wrdata;
      end
      rddata <= mem[addr];
   end

   // Record every write as {addr, data}
   always @(posedge clk) begin
      if (wren === 1'b1) wq.push_back({addr, wrdata});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Textbook ARC4 key schedule over an identity permutation
   function automatic void ksa_model(input logic [23:0] k);
      int s [0:255];
      int j, t, kb;
      int kv;
      kv = int'(k);
      for (int i = 0; i < 256; i++) s[i] = i;
      j = 0;
      for (int i = 0; i < 256; i++) begin
         kb = (kv >> (8 * (2 - (i % 3)))) & 255;
         j = (j + s[i] + kb) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
      end
      for (int i = 0; i < 256; i++) gold[i] = s[i];
   endfunction

   task automatic check_mem(input string tag);
      int nbad;
      nbad = 0;
      for (int x = 0; x < 256; x++) if (mem[x] !== 8'(gold[x])) nbad++;
      check(tag, nbad, 0);
   endtask

   // Fill S with identity, then issue a one-cycle start with key k
   task automatic start_run(input logic [23:0] k);
      @(negedge clk); fill_req = 1'b1;
      @(negedge clk); fill_req = 1'b0;
      wq.delete();
      key = k; en = 1'b1;
      @(negedge clk); en = 1'b0;
   endtask

   // Count busy cycles until rdy returns; optionally toggle en/key while busy
   task automatic finish_run(input bit noise, input logic [23:0] k, output int cycles);
      cycles = 0;
      while (rdy !== 1'b1 && cycles < 3000) begin
         cycles++;
         if (noise) begin
            en  = 1'($urandom);
            key = 24'($urandom);
         end
         @(negedge clk);
      end
      en = 1'b0;
      key = k;
   endtask

   initial begin
      int cyc;
      int nw;
      logic [23:0] rk;
      n_total = 0; n_pass = 0;
      rst = 1'b0; en = 1'b0; key = 24'h000000; fill_req = 1'b0;

      // Asynchronous reset, checked before any clock edge
      #1 rst = 1'b1;
      #1;
      check("reset_rdy",  32'(rdy),  32'd1);
      check("reset_wren", 32'(wren), 32'd0);
      check("reset_addr", 32'(addr), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Key 1E4600: first swap pair of two iterations
      start_run(24'h1E4600);
      check("busy_after_start", 32'(rdy), 32'd0);
      finish_run(1'b0, 24'h1E4600, cyc);
      check("lat_1e4600", cyc, 1280);
      check("nwrites_1e4600", wq.size(), 512);
      check("w0", 32'(wq[0]), 32'h001E);
      check("w1", 32'(wq[1]), 32'h1E00);
      check("w2", 32'(wq[2]), 32'h0165);
      check("w3", 32'(wq[3]), 32'h6501);
      ksa_model(24'h1E4600);
      check_mem("mem_1e4600");

      // Key 0: i==j on the first iteration
      start_run(24'h000000);
      finish_run(1'b0, 24'h000000, cyc);
      check("w0_zero", 32'(wq[0]), 32'h0000);
      check("w1_zero", 32'(wq[1]), 32'h0000);
      ksa_model(24'h000000);
      check_mem("mem_zero");

      // en pulses and key changes while busy are ignored
      start_run(24'h00033C);
      finish_run(1'b1, 24'h00033C, cyc);
      check("lat_noise", cyc, 1280);
      repeat (3) @(negedge clk);
      check("idle_after_noise", 32'(rdy), 32'd1);
      ksa_model(24'h00033C);
      check_mem("mem_033c_noise");

      // Mid-run reset at i=0x80
      start_run(24'hA5C3F0);
      repeat (640) @(negedge clk);
      check("mid_addr", 32'(addr), 32'h80);
      check("mid_busy", 32'(rdy),  32'd0);
      nw = wq.size();
      #1 rst = 1'b1;
      #1;
      check("mid_rst_wren",   32'(wren),   32'd0);
      check("mid_rst_rdy",    32'(rdy),    32'd1);
      check("mid_rst_addr",   32'(addr),   32'd0);
      check("mid_rst_wrdata", 32'(wrdata), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("no_writes_after_rst", wq.size(), nw);

      // Fresh full run after reset, golden key 00033C
      start_run(24'h00033C);
      finish_run(1'b0, 24'h00033C, cyc);
      check("lat_after_rst", cyc, 1280);
      check_mem("mem_033c");

      // Random keys
      for (int r = 0; r < 3; r++) begin
         rk = 24'($urandom);
         start_run(rk);
         finish_run(1'b0, rk, cyc);
         check("lat_rand", cyc, 1280);
         ksa_model(rk);
         check_mem("mem_rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
